// File: rtl/video_fetch_arbiter_if.sv
// Bus bundle around the video fetch arbiter.
//   mem_*  : single-port RAM port. The arbiter drives en/we/addr/wdata;
//            the RAM returns rdata one cycle after a read strobe.
//   cpu_*  : CPU request port. The CPU holds req/we/addr/wdata until it
//            sees ack; the arbiter returns a one-cycle ack pulse and the
//            registered read data.
// Modports:
//   slave  : the arbiter's view (serves the CPU, owns the RAM port)
//   master : the environment's view (CPU plus RAM)
interface video_fetch_arbiter_if;
  logic        mem_en;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        cpu_req;
  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;

  modport slave (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );

  modport master (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/video_fetch_arbiter.sv
// Video fetch arbiter for a 640x480 (800x525 total) RGB332 framebuffer
// packed 4 pixels per 32-bit word. Video fetches own the RAM on fetch
// slots; the CPU gets any other cycle.
// Ports:
//   clk       pixel clock, rising edge
//   resetn    asynchronous active-low reset
//   in_x/in_y raster position (0..799 / 0..524)
//   in_blank  high outside the active area
//   fb_base   framebuffer word base, sampled once per frame
//   color     registered RGB888 pixel, 1 cycle after in_x/in_y
//   bus       RAM and CPU bus bundle (slave modport)
//
// CPU FSM
//   state   | meaning
//   ST_IDLE | waiting; issues a pending cpu_req on a non-fetch cycle
//   ST_ACK  | cpu_ack high; read data captured from the RAM
module video_fetch_arbiter (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [9:0]                in_x,
  input  logic [9:0]                in_y,
  input  logic                      in_blank,
  input  logic [16:0]               fb_base,
  output logic [23:0]               color,
  video_fetch_arbiter_if.slave      bus
);

  typedef enum logic [0:0] {ST_IDLE, ST_ACK} cpu_state_t;

  cpu_state_t  state;
  logic        we_q;
  logic        vid_pend;
  logic [16:0] base_q;
  logic [31:0] cur_word;
  logic [31:0] next_word;

  function automatic logic [16:0] row_off(input logic [9:0] y);
    return {y, 7'd0} + {2'd0, y, 5'd0};
  endfunction

  logic [9:0]  nl;
  logic        capture;
  logic        fetch_line;
  logic        fetch_next;
  logic        vid_fetch;
  logic [16:0] base_eff;
  logic [16:0] vid_addr;
  logic        cpu_issue;

  assign nl         = (in_y == 10'd524) ? 10'd0 : in_y + 10'd1;
  assign capture    = (in_y == 10'd524) && (in_x == 10'd797);
  assign fetch_line = (in_x[1:0] == 2'd1) && (in_x < 10'd636) && (in_y < 10'd480);
  assign fetch_next = (in_x == 10'd797) && (nl < 10'd480);
  assign vid_fetch  = fetch_line || fetch_next;
  // The new base applies to the capture cycle's own fetch (first line of the frame).
  assign base_eff   = capture ? fb_base : base_q;
  assign vid_addr   = fetch_next ? (base_eff + row_off(nl))
                                 : (base_eff + row_off(in_y) + {9'd0, in_x[9:2]} + 17'd1);
  // resetn gates only CPU traffic; video decode stays live through reset.
  assign cpu_issue  = resetn && (state == ST_IDLE) && bus.cpu_req && !vid_fetch;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 17'd0;
    bus.mem_wdata = 32'd0;
    if (vid_fetch) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = vid_addr;
    end else if (cpu_issue) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  // At x%4==0 the word for this group has only just landed in next_word.
  logic [31:0] word_sel;
  logic [7:0]  pix;
  logic [23:0] rgb;

  assign word_sel = (in_x[1:0] == 2'd0) ? next_word : cur_word;

  always_comb begin
    pix = word_sel[7:0];
    case (in_x[1:0])
      2'd0: pix = word_sel[7:0];
      2'd1: pix = word_sel[15:8];
      2'd2: pix = word_sel[23:16];
      2'd3: pix = word_sel[31:24];
      default: pix = word_sel[7:0];
    endcase
  end

  assign rgb = {pix[7:5], pix[7:5], pix[7:6],
                pix[4:2], pix[4:2], pix[4:3],
                pix[1:0], pix[1:0], pix[1:0], pix[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      color         <= 24'd0;
      vid_pend      <= 1'b0;
      next_word     <= 32'd0;
      cur_word      <= 32'd0;
      base_q        <= 17'd0;
      state         <= ST_IDLE;
      we_q          <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= 32'd0;
    end else begin
      vid_pend <= vid_fetch;
      if (vid_pend)
        next_word <= bus.mem_rdata;
      if (in_x[1:0] == 2'd0)
        cur_word <= next_word;
      if (capture)
        base_q <= fb_base;
      color <= in_blank ? 24'd0 : rgb;

      case (state)
        ST_IDLE: begin
          bus.cpu_ack <= 1'b0;
          if (cpu_issue) begin
            state       <= ST_ACK;
            we_q        <= bus.cpu_we;
            bus.cpu_ack <= 1'b1;
          end
        end
        ST_ACK: begin
          bus.cpu_ack <= 1'b0;
          if (!we_q)
            bus.cpu_rdata <= bus.mem_rdata;
          state <= ST_IDLE;
        end
        default: begin
          bus.cpu_ack <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
